// File: rtl/i2c_frame_scheduler.sv
// Round-robin scheduler sharing one byte-level I2C master engine among N_REQ frame requesters (NACK retry under I2C_SCHED_RETRY_EN).
// Latency: gnt/busy and the START command one cycle after req is sampled in IDLE; two cycles per command at full engine speed.
// Backpressure: each command holds cmd_valid/cmd_op/cmd_data until cmd_ready; peer_busy holds off new frames only.
module i2c_frame_scheduler #(
   parameter int         N_REQ       = 2,
   parameter int         FRAME_BYTES = 4,
   parameter logic [6:0] SLAVE_ADDR  = 7'h55,
   parameter int         MAX_RETRY   = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_REQ-1:0]               req,
   input  logic [N_REQ*FRAME_BYTES*8-1:0] req_data,
   input  logic                           peer_busy,
   output logic [N_REQ-1:0]               gnt,
   output logic [N_REQ-1:0]               done,
   output logic [N_REQ-1:0]               err,
   output logic                           busy,
   output logic                           cmd_valid,
   output logic [1:0]                     cmd_op,
   output logic [7:0]                     cmd_data,
   input  logic                           cmd_ready,
   input  logic                           rsp_valid,
   input  logic                           rsp_nack
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_REPORT} state_t;

   state_t           state, state_nxt;
   logic [N_REQ-1:0] gnt_q, gnt_nxt;
   logic [IW-1:0]    cur_idx, cur_idx_nxt;
   logic [IW-1:0]    last_gnt, last_gnt_nxt;
   logic [IW-1:0]    arb_idx, cand_idx;
   logic             arb_found;
   logic [BW-1:0]    byte_cnt, byte_cnt_nxt;
   logic             fail, fail_nxt;
   logic             cmd_sent, cmd_sent_nxt;
   logic             load_frame;
   logic             rsp_hit;
   logic [7:0]       frame_buf [FRAME_BYTES];
`ifdef I2C_SCHED_RETRY_EN
   logic [2:0]       retry_cnt, retry_cnt_nxt;
`endif

   // Round-robin pick: first set req bit searching upward from last_gnt+1, wrapping.
   always_comb begin
      arb_idx   = '0;
      arb_found = 1'b0;
      cand_idx  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand_idx = IW'((int'(last_gnt) + k) % N_REQ);
         if (!arb_found && req[cand_idx]) begin
            arb_found = 1'b1;
            arb_idx   = cand_idx;
         end
      end
   end

   // Next-state and command outputs; a command is outstanding once accepted until its response.
   always_comb begin
      state_nxt    = state;
      gnt_nxt      = gnt_q;
      cur_idx_nxt  = cur_idx;
      last_gnt_nxt = last_gnt;
      byte_cnt_nxt = byte_cnt;
      fail_nxt     = fail;
      cmd_sent_nxt = cmd_sent;
      load_frame   = 1'b0;
      cmd_valid    = 1'b0;
      cmd_op       = OP_START;
      cmd_data     = 8'h00;
      rsp_hit      = cmd_sent && rsp_valid;
`ifdef I2C_SCHED_RETRY_EN
      retry_cnt_nxt = retry_cnt;
`endif
      case (state)
         S_IDLE: begin
            if (arb_found && !peer_busy) begin
               state_nxt    = S_START;
               gnt_nxt      = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
               cur_idx_nxt  = arb_idx;
               load_frame   = 1'b1;
               byte_cnt_nxt = '0;
               fail_nxt     = 1'b0;
               cmd_sent_nxt = 1'b0;
`ifdef I2C_SCHED_RETRY_EN
               retry_cnt_nxt = '0;
`endif
            end
         end
         S_START: begin
            cmd_valid = !cmd_sent;
            cmd_op    = OP_START;
            if (rsp_hit) state_nxt = S_ADDR;
         end
         S_ADDR: begin
            cmd_valid = !cmd_sent;
            cmd_op    = OP_WRITE;
            cmd_data  = {SLAVE_ADDR, 1'b0};
            if (rsp_hit) begin
               if (rsp_nack) begin
                  fail_nxt  = 1'b1;
                  state_nxt = S_STOP;
               end else begin
                  byte_cnt_nxt = '0;
                  state_nxt    = S_DATA;
               end
            end
         end
         S_DATA: begin
            cmd_valid = !cmd_sent;
            cmd_op    = OP_WRITE;
            cmd_data  = frame_buf[byte_cnt];
            if (rsp_hit) begin
               if (rsp_nack) begin
                  fail_nxt  = 1'b1;
                  state_nxt = S_STOP;
               end else if (byte_cnt == BW'(FRAME_BYTES-1)) begin
                  state_nxt = S_STOP;
               end else begin
                  byte_cnt_nxt = byte_cnt + BW'(1);
               end
            end
         end
         S_STOP: begin
            cmd_valid = !cmd_sent;
            cmd_op    = OP_STOP;
            if (rsp_hit) begin
               state_nxt = S_REPORT;
`ifdef I2C_SCHED_RETRY_EN
               // Failed attempt with retries left: replay the buffered frame from START.
               if (fail && (retry_cnt < 3'(MAX_RETRY))) begin
                  retry_cnt_nxt = retry_cnt + 3'd1;
                  fail_nxt      = 1'b0;
                  byte_cnt_nxt  = '0;
                  state_nxt     = S_START;
               end
`endif
            end
         end
         S_REPORT: begin
            last_gnt_nxt = cur_idx;
            gnt_nxt      = '0;
            state_nxt    = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (cmd_valid && cmd_ready) cmd_sent_nxt = 1'b1;
      else if (rsp_hit)           cmd_sent_nxt = 1'b0;
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         gnt_q    <= '0;
         cur_idx  <= '0;
         last_gnt <= IW'(N_REQ-1);
         byte_cnt <= '0;
         fail     <= 1'b0;
         cmd_sent <= 1'b0;
`ifdef I2C_SCHED_RETRY_EN
         retry_cnt <= '0;
`endif
      end else begin
         state    <= state_nxt;
         gnt_q    <= gnt_nxt;
         cur_idx  <= cur_idx_nxt;
         last_gnt <= last_gnt_nxt;
         byte_cnt <= byte_cnt_nxt;
         fail     <= fail_nxt;
         cmd_sent <= cmd_sent_nxt;
`ifdef I2C_SCHED_RETRY_EN
         retry_cnt <= retry_cnt_nxt;
`endif
      end
   end

   // Capture the winner's payload at grant so later req_data changes do not affect the frame.
   always_ff @(posedge clk) begin
      if (load_frame) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
               for (int k = 0; k < FRAME_BYTES; k++) begin
                  frame_buf[k] <= req_data[(i*FRAME_BYTES+k)*8 +: 8];
               end
            end
         end
      end
   end

   assign gnt  = gnt_q;
   assign busy = (state != S_IDLE);
   assign done = (state == S_REPORT && !fail) ? gnt_q : '0;
   assign err  = (state == S_REPORT &&  fail) ? gnt_q : '0;

endmodule

// File: tb/tb_i2c_frame_scheduler.sv
// Directed bench for i2c_frame_scheduler with an engine model and a command scoreboard.
// Expected engine commands are queued when a frame is set up and popped as the engine accepts them.
// Default parameters: N_REQ=2, FRAME_BYTES=4, SLAVE_ADDR=7'h55, MAX_RETRY=3.
`timescale 1ns/1ps
module tb_i2c_frame_scheduler;
   localparam int          N_REQ  = 2;
   localparam int          FB     = 4;
   localparam int          MAX_R  = 3;
   localparam logic [7:0]  ADDR_W = {7'h55, 1'b0};
   localparam logic [31:0] P0     = 32'h44332211;
   localparam logic [31:0] P1     = 32'h88776655;
   localparam logic [31:0] PJ     = 32'hDEC0BE07;
   localparam int          LEN    = 2*(FB+3)+1;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req;
   logic [63:0]  req_data;
   logic         peer_busy;
   logic [1:0]   gnt, done, err;
   logic         busy, cmd_valid, cmd_ready, rsp_valid, rsp_nack;
   logic [1:0]   cmd_op;
   logic [7:0]   cmd_data;

   int          pass_cnt = 0;
   int          chk_cnt  = 0;
   logic [9:0]  exp_q [$];
   int          test_id = 0;
   int          addr_nack_cfg = 0;
   int          data_nack_cfg = -1;
   bit          stall = 1'b0;
   bit          spur_rsp = 1'b0;
   int          model_last = N_REQ-1;

   i2c_frame_scheduler #(.N_REQ(N_REQ), .FRAME_BYTES(FB), .SLAVE_ADDR(7'h55), .MAX_RETRY(MAX_R)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .peer_busy(peer_busy),
      .gnt(gnt), .done(done), .err(err), .busy(busy),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .rsp_valid(rsp_valid), .rsp_nack(rsp_nack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push_attempt(input logic [31:0] p, input int n_data);
      exp_q.push_back({2'b00, 8'h00});
      exp_q.push_back({2'b01, ADDR_W});
      for (int k = 0; k < n_data; k++) exp_q.push_back({2'b01, p[k*8 +: 8]});
      exp_q.push_back({2'b10, 8'h00});
   endtask

   function automatic int rr_pick(input int last, input logic [1:0] r);
      for (int k = 1; k <= N_REQ; k++) if (r[(last+k)%N_REQ]) return (last+k)%N_REQ;
      return 0;
   endfunction

   // Called at the negedge where the grant is first visible; returns at the idle cycle after REPORT.
   task automatic run_frame(input string tag, input logic [1:0] exp_g, input bit exp_ok,
                            input int exp_len, input bit drop);
      int cyc; bit held; bit seen;
      cyc = 0; held = 1'b1; seen = 1'b0;
      while (!seen && cyc < 300) begin
         if (gnt !== exp_g || busy !== 1'b1) held = 1'b0;
         if ((done | err) != 2'b00) seen = 1'b1;
         else begin @(negedge clk); cyc++; end
      end
      check({tag, "_seen"}, 32'(seen), 1);
      check({tag, "_done"}, 32'(done), exp_ok ? 32'(exp_g) : 0);
      check({tag, "_err"},  32'(err),  exp_ok ? 0 : 32'(exp_g));
      check({tag, "_gnt_held"}, 32'(held), 1);
      if (exp_len > 0) check({tag, "_len"}, cyc+1, exp_len);
      check({tag, "_q_empty"}, exp_q.size(), 0);
      if (drop) req = 2'b00;
      model_last = exp_g[1] ? 1 : 0;
      @(negedge clk);
      check({tag, "_idle_gap"}, 32'({gnt, busy}), 0);
   endtask

   // Engine model: acts just after each rising edge, replies one cycle after acceptance.
   initial begin : engine
      int seen_test; int addr_nacks; bit data_nacked; bit pend; bit pend_nack; int wr_idx;
      logic [9:0] e;
      seen_test = -1; addr_nacks = 0; data_nacked = 1'b0; pend = 1'b0; pend_nack = 1'b0; wr_idx = 0;
      cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_nack = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (seen_test != test_id) begin
            seen_test = test_id; addr_nacks = 0; data_nacked = 1'b0;
         end
         rsp_valid = 1'b0; rsp_nack = 1'b0;
         cmd_ready = !stall;
         if (!reset) begin
            pend = 1'b0; wr_idx = 0;
         end else begin
            if (pend) begin
               rsp_valid = 1'b1; rsp_nack = pend_nack; pend = 1'b0;
            end else if (spur_rsp) begin
               rsp_valid = 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
               if (exp_q.size() == 0) check("cmd_unexpected", 32'({cmd_op, cmd_data}), 32'h3ff);
               else begin
                  e = exp_q.pop_front();
                  check("cmd_seq", 32'({cmd_op, cmd_data}), 32'(e));
               end
               pend = 1'b1; pend_nack = 1'b0;
               if (cmd_op == 2'b00) wr_idx = 0;
               else if (cmd_op == 2'b01) begin
                  if (wr_idx == 0 && addr_nacks < addr_nack_cfg) begin
                     pend_nack = 1'b1; addr_nacks++;
                  end else if (data_nack_cfg >= 0 && wr_idx == data_nack_cfg+1 && !data_nacked) begin
                     pend_nack = 1'b1; data_nacked = 1'b1;
                  end
                  wr_idx++;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      bit ok; int n; int g;
      reset = 1'b0; req = 2'b00; req_data = {P1, P0}; peer_busy = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", 32'({gnt, done, err, busy, cmd_valid, cmd_op, cmd_data}), 0);

      // peer_busy hold-off, then a stalled START with stray responses
      reset = 1'b1; peer_busy = 1'b1; stall = 1'b1; req = 2'b01;
      push_attempt(P0, FB);
      ok = 1'b1;
      repeat (10) begin @(negedge clk); if (gnt !== 2'b00 || busy !== 1'b0) ok = 1'b0; end
      check("holdoff_no_gnt", 32'(ok), 1);
      peer_busy = 1'b0;
      @(negedge clk);
      check("holdoff_grant", 32'({gnt, busy, cmd_valid, cmd_op, cmd_data}), 32'({2'b01, 1'b1, 1'b1, 2'b00, 8'h00}));
      spur_rsp = 1'b1; ok = 1'b1;
      repeat (5) begin @(negedge clk); if ({cmd_valid, cmd_op, cmd_data} !== {1'b1, 2'b00, 8'h00}) ok = 1'b0; end
      check("stall_stable", 32'(ok), 1);
      spur_rsp = 1'b0; stall = 1'b0;
      run_frame("stall_frame", 2'b01, 1'b1, 0, 1'b1);

      // clean frame: latency, length, mid-frame input changes ignored
      push_attempt(P0, FB);
      req = 2'b01;
      @(negedge clk);
      check("lat_grant", 32'({gnt, busy, cmd_valid, cmd_op}), 32'({2'b01, 1'b1, 1'b1, 2'b00}));
      peer_busy = 1'b1; req_data = {P1, PJ}; req = 2'b11;
      run_frame("clean", 2'b01, 1'b1, LEN, 1'b1);
      peer_busy = 1'b0; req_data = {P1, P0};

      // round-robin with both requesters held
      req = 2'b11;
      for (int f = 0; f < 3; f++) begin
         g = rr_pick(model_last, req);
         push_attempt(g == 1 ? P1 : P0, FB);
         @(negedge clk);
         check("rr_gnt", 32'({gnt, busy}), 32'({2'(1 << g), 1'b1}));
         run_frame("rr_frame", 2'(1 << g), 1'b1, LEN, f == 2);
      end

`ifdef I2C_SCHED_RETRY_EN
      test_id++; addr_nack_cfg = 2; data_nack_cfg = -1;
      push_attempt(P0, 0); push_attempt(P0, 0); push_attempt(P0, FB);
      req = 2'b01;
      @(negedge clk);
      check("retry_gnt", 32'(gnt), 32'h1);
      run_frame("retry_ok", 2'b01, 1'b1, 0, 1'b1);
      test_id++; addr_nack_cfg = MAX_R + 1;
      for (int a = 0; a <= MAX_R; a++) push_attempt(P0, 0);
      req = 2'b01;
      @(negedge clk);
      check("exhaust_gnt", 32'(gnt), 32'h1);
      run_frame("retry_exhaust", 2'b01, 1'b0, 0, 1'b1);
`else
      test_id++; addr_nack_cfg = 0; data_nack_cfg = 2;
      push_attempt(P0, 3);
      req = 2'b01;
      @(negedge clk);
      check("dnack_gnt", 32'(gnt), 32'h1);
      run_frame("data_nack", 2'b01, 1'b0, 0, 1'b1);
`endif
      test_id++; addr_nack_cfg = 0; data_nack_cfg = -1;

      // reset during DATA, then a pending requester 1
      push_attempt(P0, FB);
      req = 2'b01;
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'h1);
      n = 0;
      while (!(cmd_valid && cmd_op == 2'b01 && cmd_data == 8'h11) && n < 40) begin @(negedge clk); n++; end
      check("rst_reach_data", 32'({cmd_valid, cmd_op, cmd_data}), 32'({1'b1, 2'b01, 8'h11}));
      reset = 1'b0; req = 2'b10; exp_q.delete();
      @(negedge clk);
      check("rst_mid_outs", 32'({gnt, done, err, busy, cmd_valid, cmd_op, cmd_data}), 0);
      model_last = N_REQ-1;
      g = rr_pick(model_last, req);
      push_attempt(g == 1 ? P1 : P0, FB);
      reset = 1'b1;
      @(negedge clk);
      check("rst_first_gnt", 32'({gnt, busy}), 32'({2'(1 << g), 1'b1}));
      run_frame("post_rst", 2'(1 << g), 1'b1, LEN, 1'b1);

      // reset in IDLE restores round-robin priority to requester 0
      reset = 1'b0; req = 2'b11;
      @(negedge clk);
      reset = 1'b1; model_last = N_REQ-1;
      g = rr_pick(model_last, req);
      push_attempt(g == 1 ? P1 : P0, FB);
      @(negedge clk);
      check("rst_rr_first", 32'(gnt), 32'(2'(1 << g)));
      run_frame("rst_rr_frame", 2'(1 << g), 1'b1, LEN, 1'b1);

      check("final_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
